// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider.
// One trial subtraction (WIDTH+1 bits wide) per clock, quotient bits MSB first.
// Operands arrive over an in_valid/in_ready handshake; quotient, remainder and
// div_by_zero leave over an out_valid/out_ready handshake. All outputs are
// registered, and only one operation is in flight at a time.
// Optional feature: define DIV_SIGNED_EN for two's-complement operands. This
// divides magnitudes and adds a FIXUP state that restores the result signs.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
`ifdef DIV_SIGNED_EN
        FIXUP = 2'd2,
`endif
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] dvd;      // dividend being shifted in (magnitude in signed mode)
    logic [WIDTH-1:0] dvs;      // divisor (magnitude in signed mode)
    logic [WIDTH-1:0] raw_dvd;  // dividend as presented; it is the remainder on divide-by-zero
    logic [WIDTH-1:0] r;        // partial remainder
    logic [WIDTH-1:0] q;        // quotient under construction
    logic [CW-1:0]    cnt;      // index of the quotient bit resolved this cycle

`ifdef DIV_SIGNED_EN
    logic neg_q;                // operand signs differ
    logic neg_r;                // dividend was negative

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        // The most-negative value maps to itself, which is also its correct unsigned magnitude.
        return v[WIDTH-1] ? -v : v;
    endfunction
`endif

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    // One restoring step: shift in the next dividend bit, then try to subtract the divisor.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        r_shift     = {r, dvd[cnt]};
        trial       = r_shift - {1'b0, dvs};
        q_next      = q;
        q_next[cnt] = ~trial[WIDTH];
        r_next      = trial[WIDTH] ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
    end

    // Control FSM and datapath registers. All outputs are registered here.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments. Every register then
        // samples pre-edge values, no matter what order the statements are in.
        if (reset) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            dvd         <= '0;
            dvs         <= '0;
            raw_dvd     <= '0;
            r           <= '0;
            q           <= '0;
`ifdef DIV_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        raw_dvd     <= dividend;
`ifdef DIV_SIGNED_EN
                        dvd         <= magnitude(dividend);
                        dvs         <= magnitude(divisor);
                        neg_q       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_r       <= dividend[WIDTH-1];
`else
                        dvd         <= dividend;
                        dvs         <= divisor;
`endif
                        r           <= '0;
                        q           <= '0;
                        cnt         <= CW'(WIDTH - 1);
                        div_by_zero <= 1'b0;
                        in_ready    <= 1'b0;
                        busy        <= 1'b1;
                        state       <= CALC;
                    end
                end
                CALC: begin
                    if (dvs == '0) begin
                        // A zero divisor skips the iterations and reports at once.
                        quotient    <= '1;
                        remainder   <= raw_dvd;
                        div_by_zero <= 1'b1;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        r <= r_next;
                        q <= q_next;
                        if (cnt == '0) begin
`ifdef DIV_SIGNED_EN
                            state     <= FIXUP;
`else
                            quotient  <= q_next;
                            remainder <= r_next;
                            out_valid <= 1'b1;
                            state     <= DONE;
`endif
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                end
`ifdef DIV_SIGNED_EN
                FIXUP: begin
                    // For most-negative / -1 the signs match and the magnitude quotient
                    // wraps to the most-negative value with a zero remainder.
                    quotient  <= neg_q ? -q : q;
                    remainder <= neg_r ? -r : r;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=4). A plain-arithmetic reference
// model sets the expected results, latency and handshake spacing.
// Define DIV_SIGNED_EN for both the bench and the RTL to check the signed build.
module tb_seq_divider;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         busy;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    int last_hs     = 0;
    int last_lat    = 0;
    bit spacing_on  = 0;
    bit have_prev   = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    // Reference model: integer division as defined for the build's operand type.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            int sa;
            int sb;
            sa = $signed(a);
            sb = $signed(b);
            q = W'(sa / sb);
            r = W'(sa % sb);
`else
            q = a / b;
            r = a % b;
`endif
            z = 1'b0;
        end
    endfunction

    function automatic int exp_lat(input logic [W-1:0] b);
        if (b == '0) return 1;
`ifdef DIV_SIGNED_EN
        return W + 1;
`else
        return W;
`endif
    endfunction

    task automatic wait_in_ready();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout got=%b exp=1", in_ready);
        end
    endtask

    // One complete operation. The result is held under back-pressure for
    // `stall` cycles. With `noise` set, in_valid stays high with junk operands
    // while the divider is busy; those operands must be ignored.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int stall, input bit noise);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
        int           lat;
        model(a, b, eq, er, ez);
        out_ready = (stall == 0);
        wait_in_ready();
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (spacing_on && have_prev) begin
            checks++;
            if (cycle - last_hs !== last_lat + 2) begin
                errors++;
                $display("FAIL spacing a=%0d b=%0d got=%0d exp=%0d", a, b, cycle - last_hs, last_lat + 2);
            end
        end
        last_hs   = cycle;
        last_lat  = exp_lat(b);
        have_prev = 1'b1;
        in_valid  = noise;
        dividend  = W'($urandom);
        divisor   = W'($urandom);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_accept a=%0d b=%0d got busy=%b in_ready=%b exp busy=1 in_ready=0",
                     a, b, busy, in_ready);
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        checks++;
        if (lat !== exp_lat(b)) begin
            errors++;
            $display("FAIL latency a=%0d b=%0d got=%0d exp=%0d", a, b, lat, exp_lat(b));
        end
        checks++;
        if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
            errors++;
            $display("FAIL result a=%0d b=%0d got q=%0h r=%0h z=%b exp q=%0h r=%0h z=%b",
                     a, b, quotient, remainder, div_by_zero, eq, er, ez);
        end
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== eq ||
                remainder !== er || div_by_zero !== ez) begin
                errors++;
                $display("FAIL hold a=%0d b=%0d cyc=%0d got v=%b rdy=%b q=%0h r=%0h z=%b exp v=1 rdy=0 q=%0h r=%0h z=%b",
                         a, b, i, out_valid, in_ready, quotient, remainder, div_by_zero, eq, er, ez);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL release a=%0d b=%0d got v=%b rdy=%b busy=%b exp v=0 rdy=1 busy=0",
                     a, b, out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b v=%b busy=%b q=%0h r=%0h z=%b exp rdy=1 v=0 busy=0 q=0 r=0 z=0",
                     in_ready, out_valid, busy, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_directed();
        run_op(4'd13, 4'd3, 0, 1'b0);
        run_op(4'd7,  4'd0, 0, 1'b0);
        run_op(4'd0,  4'd5, 0, 1'b0);
        run_op(4'hF,  4'hF, 0, 1'b0);
        run_op(4'b1001, 4'd2, 0, 1'b0);
        run_op(4'b1000, 4'b1111, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_op(4'd15, 4'd1, 3, 1'b0);
        run_op(4'd6,  4'd0, 2, 1'b0);
    endtask

    task automatic test_reset_abort();
        int seen;
        out_ready = 1'b1;
        wait_in_ready();
        dividend = 4'd9;
        divisor  = 4'd2;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_state got rdy=%b v=%b q=%0h busy=%b exp rdy=1 v=0 q=0 busy=0",
                     in_ready, out_valid, quotient, busy);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_result got=%0d exp=0", seen);
        end
        run_op(4'd9, 4'd2, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        spacing_on = 1'b1;
        have_prev  = 1'b0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(W'(a), W'(b), 0, 1'b0);
            end
        end
        spacing_on = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), int'($urandom_range(0, 4)), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle unsigned restoring divider. It is the inverse arithmetic path to the team's 4-bit adders: one trial subtraction per cycle, built on a WIDTH+1-bit subtract.
- Accepts a dividend/divisor pair over a valid/ready handshake and returns quotient, remainder and a divide-by-zero flag over a second valid/ready handshake.
- Sits beside the adder blocks in the lab ALU datapath.

Parameters:
- WIDTH, 4, operand/result width in bits (>=2)

Ports:
- clk  input  1  single clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- dividend  input  WIDTH  numerator, sampled on input handshake
- divisor  input  WIDTH  denominator, sampled on input handshake
- out_valid  output  1  results valid
- out_ready  input  1  consumer takes results
- quotient  output  WIDTH  dividend / divisor
- remainder  output  WIDTH  dividend mod divisor
- div_by_zero  output  1  divisor was zero
- busy  output  1  state != IDLE

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - quotient=0, remainder=0, div_by_zero=0; iteration counter=0.
  - Reset asserted mid-CALC or in DONE aborts the operation; no result is emitted.
- States:
  - IDLE: in_ready=1.
  - CALC: in_ready=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE transitions, on in_valid=1 (input handshake):
  - Latch dividend and divisor.
  - If divisor==0: go to DONE next edge with quotient=all ones, remainder=dividend, div_by_zero=1.
  - Else: go to CALC with partial remainder=0 and counter=WIDTH-1.
- CALC, once per cycle, MSB first:
  - r' = {r[WIDTH-1:0], dividend bit[counter]}.
  - Trial t = r' - divisor, computed at WIDTH+1 bits.
  - If t is non-negative (bit WIDTH = 0): r=t[WIDTH-1:0], quotient bit[counter]=1.
  - Else: r=r'[WIDTH-1:0], quotient bit[counter]=0.
  - When counter==0, go to DONE; otherwise decrement the counter.
- Latency:
  - Input handshake at edge e0; out_valid rises after edge e0+WIDTH.
  - Divide-by-zero case: out_valid rises after edge e0+1.
- DONE:
  - quotient, remainder and div_by_zero held stable while out_valid=1 and out_ready=0 (back-pressure of any length).
  - On out_valid & out_ready at an edge: go to IDLE and drop out_valid.
  - in_ready rises the cycle after the output handshake; no overlap of operations, so throughput is one result per WIDTH+2 cycles minimum.
- Outputs are registered; no combinational path from in_valid or out_ready to any output.
- div_by_zero is cleared on the next input handshake.
- Results follow quotient*divisor + remainder == dividend and remainder < divisor for all non-zero divisors.
- in_valid while not in_ready is ignored; the operands are not sampled.

Optional Feature:
- Macro DIV_SIGNED_EN.
- When defined:
  - Operands are two's complement.
  - Magnitudes are divided by the unsigned core.
  - Added FIXUP state between CALC and DONE (latency WIDTH+1):
    - Quotient is negated if the operand signs differ.
    - Remainder takes the dividend's sign.
  - Overflow (most-negative / -1): quotient=most-negative, remainder=0, div_by_zero=0.
  - Divide by zero: quotient=all ones (-1), remainder=dividend.
- When undefined: unsigned only; no FIXUP state; latency WIDTH.

Test Plan:
- WIDTH=4, 13/3 -> out_valid exactly 4 cycles after handshake; quotient=4'd4, remainder=4'd1, div_by_zero=0.
- 7/0 -> out_valid 1 cycle after handshake; quotient=4'hF, remainder=4'd7, div_by_zero=1.
- Sweep all 256 pairs with out_ready=1; non-zero divisors -> quotient/remainder match the golden model, back-to-back spacing of 6 cycles.
- 15/1 with out_ready held low 3 cycles -> quotient=4'hF, remainder=0 stable all 3 cycles; in_ready=0 until the cycle after out_ready rises.
- Reset pulse during the 2nd CALC cycle of 9/2 -> next cycle in_ready=1, out_valid=0, quotient=0; a following 9/2 returns 4/1.
- DIV_SIGNED_EN: -7/2 -> quotient=4'b1101, remainder=4'b1111 after 5 cycles; -8/-1 -> quotient=4'b1000, remainder=0.
